// File: rtl/fp32_div_iter.sv
// Iterative fp32 divider (restoring, STEPS quotient bits per clock) with start/done handshake.
// Define FDIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp32_div_iter #(
   parameter int unsigned STEPS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] n1,
   input  logic [31:0] n2,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        Overflow,
   output logic        Underflow,
   output logic        Exception
);

   typedef enum logic [1:0] {IDLE, PREP, ITER, NORM} state_t;

   localparam int unsigned ITER_CYC = 26 / STEPS;
   localparam logic [4:0]  LAST_CNT = 5'(ITER_CYC - 1);

   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic               sign_q, sign_d;
   logic signed [9:0]  ediff_q, ediff_d;
   logic [24:0]        rem_q, rem_d;
   logic [23:0]        div_q, div_d;
   logic [25:0]        quo_q, quo_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               spec_q, spec_d;
   logic [31:0]        spec_res_q, spec_res_d;
   logic               spec_exc_q, spec_exc_d;
   logic               done_q, done_d;
   logic [31:0]        result_q, result_d;
   logic               ovf_q, ovf_d, unf_q, unf_d, exc_q, exc_d;

   logic [7:0]         e1, e2;
   logic [23:0]        m1, m2;
   logic               sgn;
   logic [24:0]        r_t;
   logic [25:0]        q_t;
   logic signed [9:0]  e_n;
   logic [22:0]        frac_n;
   logic [23:0]        frac_r;
   logic               rnd;
`ifdef FDIV_RNE_EN
   logic               g_b, s_b;
`endif

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sign_d     = sign_q;
      ediff_d    = ediff_q;
      rem_d      = rem_q;
      div_d      = div_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      spec_exc_d = spec_exc_q;
      done_d     = 1'b0;
      result_d   = result_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      exc_d      = exc_q;

      e1  = a_q[30:23];
      e2  = b_q[30:23];
      m1  = (e1 == 8'h00) ? '0 : {1'b1, a_q[22:0]};
      m2  = (e2 == 8'h00) ? '0 : {1'b1, b_q[22:0]};
      sgn = a_q[31] ^ b_q[31];

      // One restoring step per loop pass; the shifted remainder never exceeds 25 bits.
      r_t = rem_q;
      q_t = quo_q;
      for (int unsigned i = 0; i < STEPS; i++) begin
         if (r_t >= {1'b0, div_q}) begin
            r_t = r_t - {1'b0, div_q};
            q_t = {q_t[24:0], 1'b1};
         end else begin
            q_t = {q_t[24:0], 1'b0};
         end
         r_t = {r_t[23:0], 1'b0};
      end

      if (quo_q[25]) begin
         frac_n = quo_q[24:2];
         e_n    = ediff_q;
      end else begin
         frac_n = quo_q[23:1];
         e_n    = ediff_q - 10'sd1;
      end
`ifdef FDIV_RNE_EN
      g_b = quo_q[25] ? quo_q[1] : quo_q[0];
      s_b = (quo_q[25] & quo_q[0]) | (rem_q != '0);
      rnd = g_b & (s_b | frac_n[0]);
`else
      rnd = 1'b0;
`endif
      frac_r = {1'b0, frac_n} + {23'd0, rnd};
      if (frac_r[23])
         e_n = e_n + 10'sd1;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = n1;
               b_d     = n2;
               state_d = PREP;
            end
         end
         PREP: begin
            sign_d     = sgn;
            ediff_d    = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
            rem_d      = {1'b0, m1};
            div_d      = m2;
            quo_d      = '0;
            cnt_d      = '0;
            spec_d     = 1'b1;
            spec_exc_d = 1'b1;
            if (e1 == 8'hFF || e2 == 8'hFF)
               spec_res_d = {sgn, 8'hFF, 23'h400000};
            else if (m2 == '0)
               spec_res_d = {sgn, 8'hFF, 23'h0};
            else if (m1 == '0) begin
               spec_res_d = {sgn, 31'h0};
               spec_exc_d = 1'b0;
            end else begin
               spec_d     = 1'b0;
               spec_exc_d = 1'b0;
            end
            state_d = ((e1 == 8'hFF) || (e2 == 8'hFF) || (m1 == '0) || (m2 == '0)) ? NORM : ITER;
         end
         ITER: begin
            rem_d = r_t;
            quo_d = q_t;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_CNT)
               state_d = NORM;
         end
         NORM: begin
            done_d  = 1'b1;
            state_d = IDLE;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            exc_d   = 1'b0;
            if (spec_q) begin
               result_d = spec_res_q;
               exc_d    = spec_exc_q;
            end else if (e_n >= 10'sd255) begin
               result_d = {sign_q, 8'hFF, 23'h0};
               ovf_d    = 1'b1;
            end else if (e_n <= 10'sd0) begin
               result_d = {sign_q, 31'h0};
               unf_d    = 1'b1;
            end else begin
               result_d = {sign_q, e_n[7:0], frac_r[22:0]};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sign_q     <= 1'b0;
         ediff_q    <= '0;
         rem_q      <= '0;
         div_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         spec_exc_q <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         exc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sign_q     <= sign_d;
         ediff_q    <= ediff_d;
         rem_q      <= rem_d;
         div_q      <= div_d;
         quo_q      <= quo_d;
         cnt_q      <= cnt_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         spec_exc_q <= spec_exc_d;
         done_q     <= done_d;
         result_q   <= result_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         exc_q      <= exc_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign result    = result_q;
   assign Overflow  = ovf_q;
   assign Underflow = unf_q;
   assign Exception = exc_q;

endmodule

// File: tb/tb_fp32_div_iter.sv
// Scoreboard bench for fp32_div_iter: directed cases plus random operands checked
// against an integer-arithmetic reference model.
module tb_fp32_div_iter;

   localparam int unsigned STEPS      = 1;
   localparam int          NORMAL_LAT = 2 + 26 / STEPS;
   localparam int          SPEC_LAT   = 2;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      logic        exc;
      int          lat;
      int          sample;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] n1 = '0, n2 = '0;
   logic        busy, done, Overflow, Underflow, Exception;
   logic [31:0] result;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   fp32_div_iter #(.STEPS(STEPS)) dut (
      .clk(clk), .rst(rst), .start(start), .n1(n1), .n2(n2),
      .busy(busy), .done(done), .result(result),
      .Overflow(Overflow), .Underflow(Underflow), .Exception(Exception)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t r;
      int e1, e2, e;
      logic s;
      longint unsigned m1, m2, num, q, rm, frac;
      bit g, st;
      e1 = int'(a[30:23]);
      e2 = int'(b[30:23]);
      s  = a[31] ^ b[31];
      r.ovf = 0; r.unf = 0; r.exc = 0; r.lat = SPEC_LAT; r.sample = 0;
      if (e1 == 255 || e2 == 255) begin
         r.res = {s, 8'hFF, 23'h400000}; r.exc = 1;
      end else if (e2 == 0) begin
         r.res = {s, 8'hFF, 23'h0}; r.exc = 1;
      end else if (e1 == 0) begin
         r.res = {s, 31'h0};
      end else begin
         r.lat = NORMAL_LAT;
         m1  = (64'd1 << 23) | 64'(a[22:0]);
         m2  = (64'd1 << 23) | 64'(b[22:0]);
         num = m1 << 25;
         q   = num / m2;
         rm  = num % m2;
         e   = e1 - e2 + 127;
         if (q >= (64'd1 << 25)) begin
            frac = (q >> 2) & 64'h7FFFFF; g = q[1]; st = q[0] | (rm != 0);
         end else begin
            frac = (q >> 1) & 64'h7FFFFF; g = q[0]; st = (rm != 0); e = e - 1;
         end
`ifdef FDIV_RNE_EN
         if (g && (st || frac[0])) frac = frac + 1;
`endif
         if (frac == (64'd1 << 23)) begin
            frac = 0; e = e + 1;
         end
         if (e >= 255) begin
            r.res = {s, 8'hFF, 23'h0}; r.ovf = 1;
         end else if (e <= 0) begin
            r.res = {s, 31'h0}; r.unf = 1;
         end else begin
            r.res = {s, 8'(e), frac[22:0]};
         end
      end
      return r;
   endfunction

   // Monitor: every done pops one expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got result %h, want no done (cycle %0d)", result, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("overflow", 32'(Overflow), 32'(e.ovf));
            chk("underflow", 32'(Underflow), 32'(e.unf));
            chk("exception", 32'(Exception), 32'(e.exc));
            chk("latency", 32'(cyc - e.sample), 32'(e.lat));
            chk("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk); n++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input exp_t e);
      start = 1'b1; n1 = a; n2 = b;
      e.sample = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic issue_rand(input logic [31:0] a, input logic [31:0] b);
      wait_idle();
      drive(a, b, model(a, b));
   endtask

   task automatic issue_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                            input logic ovf, input logic unf, input logic exc, input int lat);
      exp_t e;
      e.res = res; e.ovf = ovf; e.unf = unf; e.exc = exc; e.lat = lat; e.sample = 0;
      wait_idle();
      drive(a, b, e);
   endtask

   function automatic logic [31:0] rand_operand();
      logic [7:0] ex;
      int sel = $urandom_range(0, 19);
      if (sel == 0)      ex = 8'h00;
      else if (sel == 1) ex = 8'hFF;
      else if (sel < 5)  ex = 8'($urandom_range(1, 254));
      else               ex = 8'($urandom_range(90, 164));
      return {1'($urandom), ex, 23'($urandom)};
   endfunction

   initial begin
      exp_t e;
      int n;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_ovf", 32'(Overflow), 32'd0);
      chk("rst_unf", 32'(Underflow), 32'd0);
      chk("rst_exc", 32'(Exception), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      issue_exp(32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, NORMAL_LAT);
`ifdef FDIV_RNE_EN
      issue_exp(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, 0, 0, NORMAL_LAT);
`else
      issue_exp(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 0, 0, NORMAL_LAT);
`endif
      issue_exp(32'h3F800000, 32'h00000000, 32'h7F800000, 0, 0, 1, SPEC_LAT);
      issue_exp(32'h7F000000, 32'h3E800000, 32'h7F800000, 1, 0, 0, NORMAL_LAT);
      issue_exp(32'h00800000, 32'h40000000, 32'h00000000, 0, 1, 0, NORMAL_LAT);
      issue_exp(32'h00000000, 32'h40000000, 32'h00000000, 0, 0, 0, SPEC_LAT);
      issue_exp(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 1, SPEC_LAT);

      // Ignored mid-operation start, then back-to-back start in the done cycle.
      issue_exp(32'hC0F00000, 32'h40200000, 32'hC0400000, 0, 0, 0, NORMAL_LAT);
      repeat (5) @(negedge clk);
      start = 1'b1; n1 = 32'h3F800000; n2 = 32'h3F800000;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk); n++;
      end
      chk("b2b_done_timeout", 32'(done), 32'd1);
      e.res = 32'h40C00000; e.ovf = 0; e.unf = 0; e.exc = 0; e.lat = NORMAL_LAT; e.sample = 0;
      drive(32'h41400000, 32'h40000000, e);

      // Reset mid-operation discards the operation.
      issue_rand(32'h40000000, 32'h40400000);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", result, 32'h0);
      chk("midrst_flags", {29'd0, Overflow, Underflow, Exception}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      issue_exp(32'h40000000, 32'h3F800000, 32'h40000000, 0, 0, 0, NORMAL_LAT);

      for (int i = 0; i < 250; i++)
         issue_rand(rand_operand(), rand_operand());

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk); n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
